i2c_write_sequencer: RTL and testbench

- Single-master I2C write-transaction controller sequencing the sda/scl bus that the start-detect FSM monitors.
- Accepts a request (7-bit address + 1 data byte) and generates START, address+W, ACK check, data, ACK check and STOP via open-drain enables.
- Includes a bus-busy monitor (START/STOP detect) so it never starts while another master owns the bus, and honours slave clock stretching.

---
 rtl/i2c_write_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_sequencer.sv
// Single-master I2C write controller: START, address+W, ACK, data byte, ACK, STOP on open-drain enables.
// Watches the bus while idle so it never starts under another master, and honours slave clock stretching.
module i2c_write_sequencer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] data_i,
    input  logic       sda_in_i,
    input  logic       scl_in_i,
    output logic       sda_oe_o,
    output logic       scl_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    output logic       bus_busy_o
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 2;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SHIFT = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d, div_adv_s;
    logic [1:0]    phase_q, phase_d, phase_adv_s;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          byte_q, byte_d, nack_q, nack_d, busy_q, busy_d, done_q, done_d;
    logic          bus_busy_q, bus_busy_d, sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
    logic [1:0]    sda_sync_q, scl_sync_q;
    logic          sda_prev_q;
    logic          sda_s, scl_s, last_clk_s, stretch_s, tick_s, bit_end_s;

    assign sda_s      = sda_sync_q[1];
    assign scl_s      = scl_sync_q[1];
    assign last_clk_s = (div_q == DIV_LAST);
    // The last clock of q1 repeats until the slave lets SCL rise.
    assign stretch_s  = ((state_q == S_SHIFT) || (state_q == S_ACK) || (state_q == S_STOP)) &&
                        (phase_q == 2'd1) && last_clk_s && !scl_s;
    assign tick_s     = last_clk_s && !stretch_s;
    assign bit_end_s  = tick_s && (phase_q == 2'd3);

    // Quarter-bit divider and phase advance, shared by all active states.
    always_comb begin
        if (tick_s) begin
            div_adv_s   = {DW{1'b0}};
            phase_adv_s = phase_q + 2'd1;
        end else if (stretch_s) begin
            div_adv_s   = div_q;
            phase_adv_s = phase_q;
        end else begin
            div_adv_s   = div_q + DW'(1);
            phase_adv_s = phase_q;
        end
    end

    // Next-state, datapath and line-enable decode.
    always_comb begin
        state_d    = state_q;
        div_d      = div_adv_s;
        phase_d    = phase_adv_s;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        byte_d     = byte_q;
        nack_d     = nack_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bus_busy_d = 1'b0;
        sda_oe_d   = 1'b0;
        scl_oe_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d   = {DW{1'b0}};
                phase_d = 2'd0;
                if (!sda_s && sda_prev_q && scl_s) begin
                    bus_busy_d = 1'b1;
                end else if (sda_s && !sda_prev_q && scl_s) begin
                    bus_busy_d = 1'b0;
                end else begin
                    bus_busy_d = bus_busy_q;
                end
                // Accept uses the registered bus_busy, so a same-clock START never races it.
                if (req_i && !bus_busy_q) begin
                    shift_d    = {addr_i, 1'b0};
                    data_d     = data_i;
                    nack_d     = 1'b0;
                    byte_d     = 1'b0;
                    idx_d      = 3'd7;
                    busy_d     = 1'b1;
                    bus_busy_d = 1'b0;
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                sda_oe_d = 1'b1;
                scl_oe_d = phase_q[1];
                if (bit_end_s) begin
                    idx_d   = 3'd7;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_START;
                end
            end
            S_SHIFT: begin
                sda_oe_d = ~shift_q[idx_q];
                scl_oe_d = (phase_q == 2'd0) || (phase_q == 2'd3);
                if (bit_end_s && (idx_q == 3'd0)) begin
                    state_d = S_ACK;
                end else if (bit_end_s) begin
                    idx_d = idx_q - 3'd1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ACK: begin
                scl_oe_d = (phase_q == 2'd0) || (phase_q == 2'd3);
                if ((phase_q == 2'd2) && last_clk_s) begin
                    nack_d = sda_s;
                end else begin
                    nack_d = nack_q;
                end
                if (bit_end_s && !nack_q && !byte_q) begin
                    shift_d = data_q;
                    byte_d  = 1'b1;
                    idx_d   = 3'd7;
                    state_d = S_SHIFT;
                end else if (bit_end_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_STOP: begin
                sda_oe_d = ~phase_q[1];
                scl_oe_d = (phase_q == 2'd0);
                if (bit_end_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_DONE: begin
                div_d   = {DW{1'b0}};
                phase_d = 2'd0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                div_d   = {DW{1'b0}};
                phase_d = 2'd0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            div_q      <= {DW{1'b0}};
            phase_q    <= 2'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            data_q     <= 8'd0;
            byte_q     <= 1'b0;
            nack_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bus_busy_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_sync_q <= 2'b11;
            scl_sync_q <= 2'b11;
            sda_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            byte_q     <= byte_d;
            nack_q     <= nack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bus_busy_q <= bus_busy_d;
            sda_oe_q   <= sda_oe_d;
            scl_oe_q   <= scl_oe_d;
            sda_sync_q <= {sda_sync_q[0], sda_in_i};
            scl_sync_q <= {scl_sync_q[0], scl_in_i};
            sda_prev_q <= sda_s;
        end
    end

    assign sda_oe_o   = sda_oe_q;
    assign scl_oe_o   = scl_oe_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign nack_o     = nack_q;
    assign bus_busy_o = bus_busy_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: wired-AND bus, event-driven slave/monitor, table and random transactions.
module tb_i2c_write_sequencer;
    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] data = 8'd0;
    logic       sda_oe, scl_oe, busy, done, nack, bus_busy;
    logic       slave_pull = 1'b0, ext_sda_pull = 1'b0, ext_scl_hold = 1'b0;
    logic       sda_bus, scl_bus;

    assign sda_bus = ~(sda_oe | slave_pull | ext_sda_pull);
    assign scl_bus = ~(scl_oe | ext_scl_hold);

    i2c_write_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .data_i(data),
        .sda_in_i(sda_bus), .scl_in_i(scl_bus),
        .sda_oe_o(sda_oe), .scl_oe_o(scl_oe), .busy_o(busy), .done_o(done),
        .nack_o(nack), .bus_busy_o(bus_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Slave and bus monitor: acks by counting SCL falls after a START, records SDA at each SCL rise.
    bit ack_addr_cfg = 1'b1, ack_data_cfg = 1'b1;
    bit got_bits[$];
    int fall_cnt = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0;
    bit prev_sda = 1'b1, prev_scl = 1'b1;
    always @(negedge clk) begin
        bit s, c;
        s = sda_bus;
        c = scl_bus;
        if (prev_scl && c && prev_sda && !s) begin
            start_cnt++;
            fall_cnt = 0;
            got_bits.delete();
            slave_pull = 1'b0;
        end else if (prev_scl && c && !prev_sda && s) begin
            stop_cnt++;
        end else if (prev_scl && !c) begin
            fall_cnt++;
            case (fall_cnt)
                9:       slave_pull = ack_addr_cfg;
                10:      slave_pull = 1'b0;
                18:      slave_pull = ack_data_cfg;
                19:      slave_pull = 1'b0;
                default: ;
            endcase
        end else if (!prev_scl && c) begin
            got_bits.push_back(s);
        end
        prev_sda = s;
        prev_scl = c;
        if (done === 1'b1) done_cnt++;
    end

    // Reference model: expected SDA at each SCL rise, nack flag and done latency.
    bit exp_bits[$];
    bit exp_nack_m;
    int exp_lat_m;
    function automatic void build_expect(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad);
        logic [7:0] frame;
        int quarters;
        frame = {a, 1'b0};
        exp_bits.delete();
        for (int i = 7; i >= 0; i--) exp_bits.push_back(frame[i]);
        exp_bits.push_back(!aa);
        quarters = 4 + 9 * 4;
        if (aa) begin
            for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
            exp_bits.push_back(!ad);
            quarters += 9 * 4;
        end
        exp_bits.push_back(1'b0);
        quarters += 4;
        exp_nack_m = !aa || !ad;
        exp_lat_m  = quarters * CLK_DIV + 1;
    endfunction

    task automatic start_txn(input logic [6:0] a, input logic [7:0] d, input bit aa, input bit ad);
        ack_addr_cfg = aa;
        ack_data_cfg = ad;
        build_expect(a, d, aa, ad);
        @(negedge clk);
        req = 1'b1; addr = a; data = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("accept_busy", busy, 1);
    endtask

    // Runs from the clock after accept to the done pulse and checks the whole transaction.
    task automatic txn_body(input string tag, input bit exp_nack, input int exp_lat, input int stretch_k, input bit toggle);
        int lat, busy_low, hold_bad, stop0, done0, gv, ev;
        bit nack_at_done;
        lat = 0; busy_low = 0; hold_bad = 0; nack_at_done = 1'b0;
        stop0 = stop_cnt; done0 = done_cnt;
        for (int n = 1; n <= 3000 && lat == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                nack_at_done = nack;
                req = 1'b0;
            end else begin
                busy_low += (busy ? 0 : 1);
                if (toggle) begin
                    req  = 1'($urandom_range(0, 1));
                    addr = 7'($urandom);
                    data = 8'($urandom);
                end
            end
            if (stretch_k > 0) begin
                if (n > stretch_k && n < stretch_k + 40 && scl_oe) hold_bad++;
                if (n == stretch_k) ext_scl_hold = 1'b1;
                if (n == stretch_k + 40) ext_scl_hold = 1'b0;
            end
        end
        ext_scl_hold = 1'b0;
        req = 1'b0;
        check({tag, "_busy_low_cycles"}, busy_low, 0);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_nack"}, nack_at_done, exp_nack);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_busy_after"}, {done, busy}, 0);
        repeat (3) @(negedge clk);
        gv = 0; ev = 0;
        foreach (got_bits[i]) gv = (gv << 1) | int'(got_bits[i]);
        foreach (exp_bits[i]) ev = (ev << 1) | int'(exp_bits[i]);
        check({tag, "_bit_count"}, got_bits.size(), exp_bits.size());
        check({tag, "_bit_values"}, gv, ev);
        check({tag, "_stop_seen"}, stop_cnt - stop0, 1);
        check({tag, "_done_pulses"}, done_cnt - done0, 1);
        if (stretch_k > 0) check({tag, "_scl_driven_in_stretch"}, hold_bad, 0);
    endtask

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        bit         aa;
        bit         ad;
        bit         nk;
        int         lat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n, act, d0;
        logic [6:0] ra;
        logic [7:0] rd;
        bit raa, rad;

        vecs[0] = '{7'h50, 8'hA5, 1'b1, 1'b1, 1'b0, 321};
        vecs[1] = '{7'h50, 8'hA5, 1'b0, 1'b1, 1'b1, 177};
        vecs[2] = '{7'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 321};
        vecs[3] = '{7'h01, 8'hFF, 1'b1, 1'b1, 1'b0, 321};

        repeat (3) @(negedge clk);
        check("reset_outputs", {sda_oe, scl_oe, busy, done, nack, bus_busy}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vecs[i]) begin
            start_txn(vecs[i].a, vecs[i].d, vecs[i].aa, vecs[i].ad);
            txn_body($sformatf("vec%0d", i), vecs[i].nk, vecs[i].lat, 0, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 7'($urandom); rd = 8'($urandom);
            raa = 1'($urandom_range(0, 1)); rad = 1'($urandom_range(0, 1));
            start_txn(ra, rd, raa, rad);
            txn_body($sformatf("rand%0d", i), exp_nack_m, exp_lat_m, 0, 1'b0);
        end

        // Slave holds SCL for 40 clocks from the start of q1 of address bit 3.
        start_txn(7'h50, 8'hA5, 1'b1, 1'b1);
        txn_body("stretch", 1'b0, 321 + 39, 16 + 4 * 16 + 4, 1'b0);

        start_txn(7'h2B, 8'h3C, 1'b1, 1'b1);
        txn_body("req_toggle", exp_nack_m, exp_lat_m, 0, 1'b1);

        // Another master's START blocks the request until its STOP.
        ack_addr_cfg = 1'b1; ack_data_cfg = 1'b1;
        build_expect(7'h50, 8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        ext_sda_pull = 1'b1;
        n = 0;
        while (!bus_busy && n < 10) begin @(posedge clk); @(negedge clk); n++; end
        check("ext_start_bus_busy_clocks", (bus_busy && n <= 3) ? n : 99, 3);
        req = 1'b1; addr = 7'h50; data = 8'hA5;
        act = 0;
        repeat (20) begin @(posedge clk); @(negedge clk); act += int'(sda_oe | scl_oe | busy); end
        check("ext_busy_no_activity", act, 0);
        ext_sda_pull = 1'b0;
        n = 0;
        while (bus_busy && n < 10) begin @(posedge clk); @(negedge clk); n++; end
        check("ext_stop_clear_clocks", (!bus_busy && n <= 3) ? 1 : 0, 1);
        n = 0;
        while (!busy && n < 10) begin @(posedge clk); @(negedge clk); n++; end
        check("ext_start_after_stop", (busy && n <= 2) ? 1 : 0, 1);
        req = 1'b0;
        txn_body("ext", 1'b0, 321, 0, 1'b0);

        // Reset during data bit 4 releases everything immediately and produces no done.
        start_txn(7'h50, 8'hA5, 1'b1, 1'b1);
        repeat (16 + 9 * 16 + 3 * 16 + 4) begin @(posedge clk); @(negedge clk); end
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset_midxfer_outputs", {sda_oe, scl_oe, busy, done, nack, bus_busy}, 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("reset_no_done", done_cnt - d0, 0);
        start_txn(vecs[0].a, vecs[0].d, vecs[0].aa, vecs[0].ad);
        txn_body("post_reset", vecs[0].nk, vecs[0].lat, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
